// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and bridge state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } bridge_state_t;

endpackage

// File: rtl/apb_slave_decoder.sv
// Maps an AXI address onto one of NUM_SLAVES equal, contiguous APB windows.
module apb_slave_decoder
    import axi_lite_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          REGION_AW  = 12
) (
    input  logic [31:0]           addr,
    output logic                  hit,
    output logic [NUM_SLAVES-1:0] sel
);

    logic [32:0] off;
    logic [32:0] region;
    logic        above_base;

    // 33-bit offset so an address below the base cannot alias into a window
    assign off        = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign region     = off >> REGION_AW;
    assign above_base = (addr >= BASE_ADDR);
    assign hit        = above_base && (region < 33'(NUM_SLAVES));

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel[i] = hit && (region == 33'(i));
        end
    end

endmodule

// File: rtl/axil_apb_bridge_mp.sv
// AXI4-Lite slave to multi-completer APB master bridge: round-robin read/write
// arbitration, one APB transfer at a time, DECERR on unmapped, timeout abort.
//
//   state  | meaning
//   IDLE   | waiting for AW+W or AR, grants combinationally
//   SETUP  | psel asserted, penable low, timer loaded
//   ACCESS | penable high, waiting for pready or timer expiry
//   RESP   | bvalid/rvalid held until the master takes it
module axil_apb_bridge_mp
    import axi_lite_pkg::*;
#(
    parameter int          NUM_SLAVES     = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
    parameter int          REGION_AW      = 12,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter int          TIMEOUT_W      = 8
) (
    input  logic                       s_axi_clk,
    input  logic                       s_axi_aresetn,
    input  logic [31:0]                s_axi_awaddr,
    input  logic [2:0]                 s_axi_awprot,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [31:0]                s_axi_wdata,
    input  logic [3:0]                 s_axi_wstrb,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [31:0]                s_axi_araddr,
    input  logic [2:0]                 s_axi_arprot,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [31:0]                s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [31:0]                m_apb_paddr,
    output logic [2:0]                 m_apb_pprot,
    output logic [NUM_SLAVES-1:0]      m_apb_psel,
    output logic                       m_apb_penable,
    output logic                       m_apb_pwrite,
    output logic [31:0]                m_apb_pwdata,
    output logic [3:0]                 m_apb_pstrb,
    input  logic [NUM_SLAVES-1:0]      m_apb_pready,
    input  logic [NUM_SLAVES*32-1:0]   m_apb_prdata,
    input  logic [NUM_SLAVES-1:0]      m_apb_pslverr
);

    localparam logic [TIMEOUT_W-1:0] TIMER_LOAD = TIMEOUT_W'(TIMEOUT_CYCLES);

    bridge_state_t         state_q;
    logic                  rr_last_write;
    logic                  write_q;
    logic [31:0]           paddr_q;
    logic [2:0]            pprot_q;
    logic [31:0]           pwdata_q;
    logic [3:0]            pstrb_q;
    logic [NUM_SLAVES-1:0] psel_q;
    logic                  penable_q;
    logic [TIMEOUT_W-1:0]  timer_q;
    logic [TIMEOUT_W-1:0]  timer_next;
    logic [1:0]            resp_q;
    logic [31:0]           rdata_q;
    logic                  bvalid_q;
    logic                  rvalid_q;

    logic                  idle;
    logic                  wr_elig;
    logic                  rd_elig;
    logic                  grant_wr;
    logic                  grant_rd;
    logic [31:0]           dec_addr;
    logic                  dec_hit;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  sel_ready;
    logic                  sel_err;
    logic [31:0]           sel_rdata;

    // Gated by reset so no ready leaks out while the bridge is held in reset
    assign idle     = (state_q == IDLE) && s_axi_aresetn;
    assign wr_elig  = s_axi_awvalid && s_axi_wvalid;
    assign rd_elig  = s_axi_arvalid;
    assign grant_rd = idle && rd_elig && (!wr_elig || rr_last_write);
    assign grant_wr = idle && wr_elig && (!rd_elig || !rr_last_write);
    assign dec_addr = grant_wr ? s_axi_awaddr : s_axi_araddr;

    apb_slave_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR),
        .REGION_AW  (REGION_AW)
    ) u_decoder (
        .addr (dec_addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    assign sel_ready  = |(m_apb_pready & psel_q);
    assign sel_err    = |(m_apb_pslverr & psel_q);
    assign timer_next = timer_q - TIMEOUT_W'(1);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (psel_q[i]) begin
                sel_rdata = sel_rdata | m_apb_prdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q       <= IDLE;
            rr_last_write <= 1'b1;
            write_q       <= 1'b0;
            paddr_q       <= '0;
            pprot_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            timer_q       <= '0;
            resp_q        <= RESP_OKAY;
            rdata_q       <= '0;
            bvalid_q      <= 1'b0;
            rvalid_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_wr || grant_rd) begin
                        rr_last_write <= grant_wr;
                        write_q       <= grant_wr;
                        paddr_q       <= dec_addr;
                        pprot_q       <= grant_wr ? s_axi_awprot : s_axi_arprot;
                        pwdata_q      <= grant_wr ? s_axi_wdata : '0;
                        pstrb_q       <= grant_wr ? s_axi_wstrb : '0;
                        if (dec_hit) begin
                            psel_q  <= dec_sel;
                            state_q <= SETUP;
                        end else begin
                            resp_q   <= RESP_DECERR;
                            rdata_q  <= '0;
                            bvalid_q <= grant_wr;
                            rvalid_q <= grant_rd;
                            state_q  <= RESP;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    timer_q   <= TIMER_LOAD;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        resp_q    <= sel_err ? RESP_SLVERR : RESP_OKAY;
                        rdata_q   <= write_q ? '0 : sel_rdata;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        bvalid_q  <= write_q;
                        rvalid_q  <= !write_q;
                        state_q   <= RESP;
                    end else if (timer_next == '0) begin
                        resp_q    <= RESP_SLVERR;
                        rdata_q   <= '0;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        bvalid_q  <= write_q;
                        rvalid_q  <= !write_q;
                        state_q   <= RESP;
                    end else begin
                        timer_q <= timer_next;
                    end
                end
                RESP: begin
                    if ((bvalid_q && s_axi_bready) || (rvalid_q && s_axi_rready)) begin
                        bvalid_q <= 1'b0;
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_axi_awready = grant_wr;
    assign s_axi_wready  = grant_wr;
    assign s_axi_arready = grant_rd;
    assign s_axi_bresp   = resp_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = resp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign m_apb_paddr   = paddr_q;
    assign m_apb_pprot   = pprot_q;
    assign m_apb_psel    = psel_q;
    assign m_apb_penable = penable_q;
    assign m_apb_pwrite  = write_q;
    assign m_apb_pwdata  = pwdata_q;
    assign m_apb_pstrb   = pstrb_q;

endmodule

// File: tb/tb_axil_apb_bridge_mp.sv
// Bench for axil_apb_bridge_mp: directed scenarios plus randomized traffic
// checked against a window/memory model of the APB segment.
module tb_axil_apb_bridge_mp;

    localparam int          NS   = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]      awaddr = '0;
    logic [2:0]       awprot = '0;
    logic             awvalid = 1'b0;
    logic             awready;
    logic [31:0]      wdata = '0;
    logic [3:0]       wstrb = '0;
    logic             wvalid = 1'b0;
    logic             wready;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready = 1'b0;
    logic [31:0]      araddr = '0;
    logic [2:0]       arprot = '0;
    logic             arvalid = 1'b0;
    logic             arready;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready = 1'b0;
    logic [31:0]      paddr;
    logic [2:0]       pprot;
    logic [NS-1:0]    psel;
    logic             penable;
    logic             pwrite;
    logic [31:0]      pwdata;
    logic [3:0]       pstrb;
    logic [NS-1:0]    pready = '0;
    logic [NS*32-1:0] prdata = '0;
    logic [NS-1:0]    pslverr = '0;

    axil_apb_bridge_mp #(
        .NUM_SLAVES(NS), .BASE_ADDR(BASE), .REGION_AW(12),
        .TIMEOUT_CYCLES(16), .TIMEOUT_W(8)
    ) dut (
        .s_axi_clk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .m_apb_paddr(paddr), .m_apb_pprot(pprot), .m_apb_psel(psel), .m_apb_penable(penable),
        .m_apb_pwrite(pwrite), .m_apb_pwdata(pwdata), .m_apb_pstrb(pstrb),
        .m_apb_pready(pready), .m_apb_prdata(prdata), .m_apb_pslverr(pslverr)
    );

    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int viol = 0;
    logic psel_seen = 1'b0;

    logic [7:0]  wait_cfg [NS];
    logic [NS-1:0] err_cfg = '0;
    int          wcnt [NS];
    logic [31:0] slv_mem [NS][16];
    logic [31:0] ref_mem [NS][16];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Completers: answer after wait_cfg ACCESS cycles, otherwise drive noise
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (psel[i] && penable) begin
                if (wcnt[i] == int'(wait_cfg[i])) begin
                    pready[i] = 1'b1;
                    pslverr[i] = err_cfg[i];
                    prdata[32*i +: 32] = slv_mem[i][paddr[5:2]];
                    if (pwrite) slv_mem[i][paddr[5:2]] = merge(slv_mem[i][paddr[5:2]], pwdata, pstrb);
                end else begin
                    pready[i] = 1'b0;
                    pslverr[i] = 1'($urandom);
                    prdata[32*i +: 32] = $urandom;
                end
                wcnt[i]++;
            end else begin
                wcnt[i] = 0;
                pready[i] = 1'($urandom);
                pslverr[i] = 1'($urandom);
                prdata[32*i +: 32] = $urandom;
            end
        end
    end

    always @(negedge clk) begin
        if (psel != '0) psel_seen = 1'b1;
        if (penable) acc_cnt++;
        if ($countones(psel) > 1 || (penable && psel == '0) || (psel != '0 && (bvalid || rvalid)))
            viol++;
        if (penable && !pwrite && (pwdata != '0 || pstrb != '0)) viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r, output int lat);
        int n;
        @(negedge clk);
        awaddr = a; awprot = 3'($urandom); wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; acc_cnt = 0; psel_seen = 1'b0;
        n = 0; #1;
        while (!awready && n < 100) begin @(negedge clk); #1; n++; end
        if (!awready) begin total++; bad++; $display("FAIL aw_grant_timeout got=0 want=1"); end
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
        lat = 1; #1;
        while (!bvalid && lat < 100) begin @(negedge clk); #1; lat++; end
        if (!bvalid) begin total++; bad++; $display("FAIL bvalid_timeout got=0 want=1"); end
        r = bresp;
        @(negedge clk); bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [1:0] r, output logic [31:0] d, output int lat);
        int n;
        @(negedge clk);
        araddr = a; arprot = 3'($urandom); arvalid = 1'b1; rready = 1'b1; acc_cnt = 0; psel_seen = 1'b0;
        n = 0; #1;
        while (!arready && n < 100) begin @(negedge clk); #1; n++; end
        if (!arready) begin total++; bad++; $display("FAIL ar_grant_timeout got=0 want=1"); end
        @(negedge clk); arvalid = 1'b0;
        lat = 1; #1;
        while (!rvalid && lat < 100) begin @(negedge clk); #1; lat++; end
        if (!rvalid) begin total++; bad++; $display("FAIL rvalid_timeout got=0 want=1"); end
        r = rresp; d = rdata;
        @(negedge clk); rready = 1'b0;
    endtask

    // Expected outcome from the address map and completer configuration
    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                output logic [1:0] er, output logic [31:0] ed, output int elat, output int eacc);
        longint off;
        int idx;
        off = longint'(a) - longint'(BASE);
        if (off < 0 || off >= longint'(NS) * 4096) begin
            er = 2'b11; ed = '0; elat = 1; eacc = 0;
        end else begin
            idx = int'(off / 4096);
            if (int'(wait_cfg[idx]) >= 16) begin
                er = 2'b10; ed = '0; elat = 18; eacc = 16;
            end else begin
                er = err_cfg[idx] ? 2'b10 : 2'b00;
                ed = w ? 32'h0 : ref_mem[idx][a[5:2]];
                elat = 3 + int'(wait_cfg[idx]);
                eacc = int'(wait_cfg[idx]) + 1;
                if (w) ref_mem[idx][a[5:2]] = merge(ref_mem[idx][a[5:2]], d, s);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            bad++; $display("FAIL reset_axi_ctrl got=%b want=00000", {awready, wready, arready, bvalid, rvalid});
        end
        total++;
        if ({psel, penable, pwrite} !== '0) begin
            bad++; $display("FAIL reset_apb_ctrl got=%b want=0", {psel, penable, pwrite});
        end
        total++;
        if ({paddr, pwdata, pstrb, pprot, rdata, rresp, bresp} !== '0) begin
            bad++; $display("FAIL reset_data got=%h want=0", {paddr, pwdata, pstrb, pprot, rdata, rresp, bresp});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        wait_cfg[1] = 8'd0; err_cfg[1] = 1'b0;
        @(negedge clk);
        awaddr = 32'h4000_1004; awprot = 3'd2; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        #1;
        total++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            bad++; $display("FAIL wr_grant got=%b%b want=11", awready, wready);
        end
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; #1;
        total++;
        if (psel !== 4'b0010 || penable !== 1'b0) begin
            bad++; $display("FAIL wr_setup got psel=%b pen=%b want psel=0010 pen=0", psel, penable);
        end
        @(negedge clk); #1;
        total++;
        if (psel !== 4'b0010 || penable !== 1'b1 || paddr !== 32'h4000_1004 || pwdata !== 32'hDEADBEEF ||
            pstrb !== 4'hF || pwrite !== 1'b1 || pprot !== 3'd2) begin
            bad++; $display("FAIL wr_access got psel=%b pen=%b addr=%h data=%h strb=%h wr=%b prot=%0d want 0010 1 40001004 deadbeef f 1 2",
                            psel, penable, paddr, pwdata, pstrb, pwrite, pprot);
        end
        @(negedge clk); #1;
        total++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || psel !== '0) begin
            bad++; $display("FAIL wr_bvalid got bvalid=%b bresp=%b psel=%b want 1 00 0000", bvalid, bresp, psel);
        end
        ref_mem[1][1] = 32'hDEADBEEF;
        bready = 1'b1;
        @(negedge clk); bready = 1'b0;
    endtask

    task automatic test_read_slverr();
        logic [1:0] r; logic [31:0] d; int lat;
        wait_cfg[3] = 8'd3; err_cfg[3] = 1'b1;
        slv_mem[3][4] = 32'h1234_5678; ref_mem[3][4] = 32'h1234_5678;
        axi_read(32'h4000_3010, r, d, lat);
        total++;
        if (r !== 2'b10 || d !== 32'h1234_5678) begin
            bad++; $display("FAIL rd_slverr got resp=%b data=%h want 10 12345678", r, d);
        end
        total++;
        if (lat !== 6 || acc_cnt !== 4) begin
            bad++; $display("FAIL rd_wait_timing got lat=%0d acc=%0d want 6 4", lat, acc_cnt);
        end
        err_cfg[3] = 1'b0; wait_cfg[3] = 8'd0;
    endtask

    task automatic test_unmapped();
        logic [1:0] r; logic [31:0] d; int lat;
        axi_read(32'h4000_4000, r, d, lat);
        total++;
        if (r !== 2'b11 || d !== 32'h0 || lat !== 1 || psel_seen !== 1'b0) begin
            bad++; $display("FAIL unmapped_read got resp=%b data=%h lat=%0d psel_seen=%b want 11 0 1 0", r, d, lat, psel_seen);
        end
        axi_write(32'h3FFF_FFFC, $urandom, 4'hF, r, lat);
        total++;
        if (r !== 2'b11 || lat !== 1 || psel_seen !== 1'b0) begin
            bad++; $display("FAIL unmapped_write got resp=%b lat=%0d psel_seen=%b want 11 1 0", r, lat, psel_seen);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] r; int lat; logic [31:0] d;
        wait_cfg[2] = 8'd255;
        axi_write(32'h4000_2008, 32'hA5A5_0001, 4'hF, r, lat);
        total++;
        if (r !== 2'b10 || acc_cnt !== 16 || lat !== 18) begin
            bad++; $display("FAIL timeout_write got resp=%b acc=%0d lat=%0d want 10 16 18", r, acc_cnt, lat);
        end
        wait_cfg[2] = 8'd0;
        wait_cfg[0] = 8'd0; err_cfg[0] = 1'b0;
        d = $urandom;
        axi_write(32'h4000_000C, d, 4'hF, r, lat);
        ref_mem[0][3] = d;
        total++;
        if (r !== 2'b00 || lat !== 3) begin
            bad++; $display("FAIL after_timeout got resp=%b lat=%0d want 00 3", r, lat);
        end
    endtask

    task automatic test_collision();
        logic [31:0] wd; logic [31:0] exp_rd; logic [1:0] br0; int n; logic early; logic stable;
        do_reset();
        wait_cfg[0] = 8'd0; err_cfg[0] = 1'b0; wait_cfg[1] = 8'd0; err_cfg[1] = 1'b0;
        wd = $urandom; exp_rd = ref_mem[0][1];
        @(negedge clk);
        awaddr = 32'h4000_1008; awprot = 3'd0; wdata = wd; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        araddr = 32'h4000_0004; arprot = 3'd1; arvalid = 1'b1; rready = 1'b0;
        #1;
        total++;
        if (arready !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
            bad++; $display("FAIL collision_grant got ar=%b aw=%b w=%b want 1 0 0", arready, awready, wready);
        end
        @(negedge clk); arvalid = 1'b0;
        early = 1'b0; n = 0; #1;
        while (!rvalid && n < 20) begin if (awready) early = 1'b1; @(negedge clk); #1; n++; end
        repeat (2) begin if (awready || !rvalid) early = 1'b1; @(negedge clk); #1; end
        total++;
        if (rvalid !== 1'b1 || rdata !== exp_rd || rresp !== 2'b00) begin
            bad++; $display("FAIL collision_read got v=%b data=%h resp=%b want 1 %h 00", rvalid, rdata, rresp, exp_rd);
        end
        total++;
        if (early !== 1'b0) begin
            bad++; $display("FAIL write_held_during_read got early=%b want 0", early);
        end
        rready = 1'b1;
        @(negedge clk); rready = 1'b0; #1;
        total++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            bad++; $display("FAIL write_after_read got aw=%b w=%b want 1 1", awready, wready);
        end
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
        ref_mem[1][2] = wd;
        n = 0; #1;
        while (!bvalid && n < 20) begin @(negedge clk); #1; n++; end
        br0 = bresp;
        total++;
        if (bvalid !== 1'b1 || br0 !== 2'b00) begin
            bad++; $display("FAIL collision_write got v=%b resp=%b want 1 00", bvalid, br0);
        end
        araddr = BASE; arvalid = 1'b1; stable = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            if (bvalid !== 1'b1 || bresp !== br0 || arready !== 1'b0) stable = 1'b0;
        end
        total++;
        if (stable !== 1'b1) begin
            bad++; $display("FAIL bresp_backpressure got stable=%b want 1", stable);
        end
        arvalid = 1'b0; bready = 1'b1;
        @(negedge clk); bready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n; logic seen; logic [1:0] r; logic [31:0] d; int lat;
        wait_cfg[1] = 8'd255;
        @(negedge clk);
        araddr = 32'h4000_1000; arvalid = 1'b1; rready = 1'b1;
        n = 0; #1;
        while (!arready && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk); arvalid = 1'b0;
        n = 0; #1;
        while (!penable && n < 20) begin @(negedge clk); #1; n++; end
        total++;
        if (penable !== 1'b1) begin
            bad++; $display("FAIL mid_reach_access got pen=%b want 1", penable);
        end
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        total++;
        if (psel !== '0 || penable !== 1'b0) begin
            bad++; $display("FAIL async_reset_apb got psel=%b pen=%b want 0000 0", psel, penable);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); #1; if (rvalid || bvalid) seen = 1'b1; end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL stale_response got seen=%b want 0", seen);
        end
        rready = 1'b0; wait_cfg[1] = 8'd0;
        axi_read(32'h4000_1008, r, d, lat);
        total++;
        if (r !== 2'b00 || d !== ref_mem[1][2] || lat !== 3) begin
            bad++; $display("FAIL read_after_reset got resp=%b data=%h lat=%0d want 00 %h 3", r, d, lat, ref_mem[1][2]);
        end
    endtask

    task automatic test_random();
        logic w; logic [31:0] a; logic [31:0] d; logic [3:0] s;
        logic [1:0] r; logic [31:0] rd; int lat;
        logic [1:0] er; logic [31:0] ed; int elat; int eacc;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NS; i++) begin
                wait_cfg[i] = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 4));
                err_cfg[i] = 1'($urandom);
            end
            case ($urandom_range(0, 9))
                0: a = BASE - 32'(4 * $urandom_range(1, 4));
                1: a = BASE + 32'h4000 + 32'(4 * $urandom_range(0, 15));
                2: a = 32'hFFFF_FFF0;
                default: a = BASE + (32'($urandom_range(0, NS - 1)) << 12) + 32'(4 * $urandom_range(0, 15));
            endcase
            w = 1'($urandom); d = $urandom; s = 4'($urandom);
            model_access(w, a, d, s, er, ed, elat, eacc);
            if (w) begin
                axi_write(a, d, s, r, lat);
                rd = 32'h0;
            end else begin
                axi_read(a, r, rd, lat);
            end
            total++;
            if (r !== er || rd !== ed) begin
                bad++; $display("FAIL rand_%0d_result w=%b addr=%h got resp=%b data=%h want %b %h", t, w, a, r, rd, er, ed);
            end
            total++;
            if (lat !== elat || acc_cnt !== eacc) begin
                bad++; $display("FAIL rand_%0d_timing addr=%h got lat=%0d acc=%0d want %0d %0d", t, a, lat, acc_cnt, elat, eacc);
            end
        end
        for (int i = 0; i < NS; i++) begin wait_cfg[i] = 8'd0; err_cfg[i] = 1'b0; end
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < 16; j++) begin
                axi_read(BASE + (32'(i) << 12) + 32'(4 * j), r, rd, lat);
                total++;
                if (r !== 2'b00 || rd !== ref_mem[i][j]) begin
                    bad++; $display("FAIL mem_%0d_%0d got resp=%b data=%h want 00 %h", i, j, r, rd, ref_mem[i][j]);
                end
            end
        end
    endtask

    task automatic test_invariants();
        total++;
        if (viol !== 0) begin
            bad++; $display("FAIL apb_invariants got violations=%0d want 0", viol);
        end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            wait_cfg[i] = 8'd0;
            wcnt[i] = 0;
            for (int j = 0; j < 16; j++) begin
                slv_mem[i][j] = $urandom;
                ref_mem[i][j] = slv_mem[i][j];
            end
        end
        test_reset();
        test_single_write();
        test_read_slverr();
        test_unmapped();
        test_timeout();
        test_collision();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_apb_bridge_mp.md
Name: axil_apb_bridge_mp

Overview:
Parametrised AXI4-Lite slave to APB master bridge with N APB completers decoded from equal, contiguous address windows. It accepts reads and writes with round-robin arbitration and runs one APB transfer at a time. Unmapped accesses return DECERR, and stalled completers are terminated by a timeout. It sits between the AXI4-Lite interconnect and the peripheral APB segment, replacing the fixed 16-port bridge.

Parameters:
NUM_SLAVES, 4, number of APB completers (1..32)
BASE_ADDR, 32'h4000_0000, start of APB aperture
REGION_AW, 12, log2 bytes per completer window; completer i spans BASE_ADDR + i*2^REGION_AW
TIMEOUT_CYCLES, 16, max ACCESS cycles without pready before abort (>=1)
TIMEOUT_W, 8, timeout counter width

Ports:
s_axi_clk  in  1  clock
s_axi_aresetn  in  1  reset
s_axi_awaddr/awprot/awvalid/awready  in/in/in/out  32/3/1/1  write address channel
s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
s_axi_araddr/arprot/arvalid/arready  in/in/in/out  32/3/1/1  read address channel
s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel
m_apb_paddr  out  32  captured AXI address, unmodified
m_apb_pprot  out  3  captured awprot/arprot
m_apb_psel  out  NUM_SLAVES  one-hot select
m_apb_penable/pwrite  out  1/1  APB enable, direction
m_apb_pwdata/pstrb  out  32/4  write data and strobes; 0 on reads
m_apb_pready  in  NUM_SLAVES  per-completer ready
m_apb_prdata  in  NUM_SLAVES*32  packed; completer i at bits [32i+31:32i]
m_apb_pslverr  in  NUM_SLAVES  per-completer error

Behaviour:
- Clock s_axi_clk. Reset s_axi_aresetn: asynchronous, active-low.
- Reset values: all outputs 0, FSM IDLE, rr_last_write=1 (a read wins the first collision).
- FSM states are IDLE, SETUP, ACCESS and RESP.
- IDLE:
  - Write is eligible when awvalid&&wvalid. Read is eligible when arvalid.
  - If both are eligible, grant the direction opposite to rr_last_write. Update rr_last_write on each grant.
  - Grant pulses awready+wready together (or arready) combinationally in IDLE for exactly one cycle.
  - On grant, capture addr, prot, wdata, wstrb and direction.
  - Decode: off = addr - BASE_ADDR, computed 33-bit. Mapped iff addr >= BASE_ADDR and (off >> REGION_AW) < NUM_SLAVES.
  - Mapped -> SETUP. Unmapped -> RESP with resp 2'b11, rdata 0, no APB activity.
- SETUP: psel[idx]=1, penable=0, paddr/pwrite/pwdata/pstrb/pprot valid. Load timer with TIMEOUT_CYCLES. Go to ACCESS next cycle.
- ACCESS: psel[idx]=1, penable=1, APB outputs held stable.
  - If pready[idx]=1: latch prdata[idx] (reads only); resp = pslverr[idx] ? 2'b10 : 2'b00; go to RESP.
  - Otherwise decrement the timer. When the timer reaches 0 while pready is still 0: abort with resp 2'b10, rdata 0, go to RESP.
  - pready/pslverr of non-selected completers are ignored.
- RESP: psel=0, penable=0. bvalid (write) or rvalid (read) is held with stable data/resp until bready/rready. On handshake, go to IDLE.
  - No new AW/W/AR is accepted before that handshake.
- Latency: grant at cycle 0, SETUP at cycle 1, ACCESS at cycle 2. Zero-wait pready gives valid at cycle 3. Minimum 4 cycles per transfer.
- On a read, rdata equals prdata[idx] even when pslverr is set.
- Reset mid-operation: psel/penable drop asynchronously and the FSM returns to IDLE. A pending response is discarded, with no bvalid/rvalid after reset release.
- Never more than one psel bit high, and psel is never high outside SETUP/ACCESS.

Decomposition:
- Package axi_lite_pkg gains:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - typedef enum bridge_state_t {IDLE, SETUP, ACCESS, RESP}
- One sub-module: apb_slave_decoder. It is combinational and parametrised by NUM_SLAVES/BASE_ADDR/REGION_AW. It takes addr and outputs hit plus a one-hot select.
- FSM, timer, arbiter and response registers stay in the top module.

Test Plan:
(NUM_SLAVES=4, BASE_ADDR=0x4000_0000, REGION_AW=12, TIMEOUT_CYCLES=16)
1. Write 0x4000_1004, data 0xDEADBEEF, strb 0xF, pready[1] held high -> psel=4'b0010 at cycle 1, penable at cycle 2, paddr 0x4000_1004, pwdata 0xDEADBEEF, bvalid at cycle 3 with bresp 00.
2. Read 0x4000_3010, pready[3] after 3 wait cycles with prdata[3]=0x1234_5678 and pslverr[3]=1 -> rvalid, rdata 0x1234_5678, rresp 10.
3. Read 0x4000_4000 (unmapped) -> psel stays 0, rvalid the cycle after arready, rresp 11, rdata 0. Write 0x3FFF_FFFC -> bresp 11.
4. Write to completer 2 with pready never asserted -> psel/penable drop after 16 ACCESS cycles, bresp 10. The next transfer to completer 0 completes with OKAY.
5. AW+W and AR presented together right after reset -> read granted first, write granted after rvalid handshake. bready held low 5 cycles -> bvalid and bresp stable, arready stays 0.
6. Assert reset during ACCESS of a read -> psel/penable go to 0 in the same cycle, no rvalid after release, and the next read completes normally.
